// File: rtl/pcs_10g_tx_gearbox_param.sv
// pcs_10g_tx_gearbox_param: 66b scrambled blocks to OUT_W-bit SERDES words, header inline or on a side port
module pcs_10g_tx_gearbox_param #(
  parameter int OUT_W      = 32,
  parameter bit INLINE_HDR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [65:0]      tx_block,
  input  logic             tx_block_valid,
  output logic             tx_block_ready,
  output logic [OUT_W-1:0] tx_data,
  output logic             tx_data_valid,
  input  logic             tx_data_ready,
  output logic [1:0]       tx_header,
  output logic             tx_header_valid,
  output logic             tx_underrun
);
  localparam int BLK_W = INLINE_HDR ? 66 : 64;
  localparam int BUF_W = BLK_W + OUT_W;
  localparam int CW    = $clog2(BUF_W + 1);
  localparam int WPB   = 64 / OUT_W;
  localparam logic [CW-1:0] OW   = CW'(OUT_W);
  localparam logic [CW-1:0] BK   = CW'(BLK_W);
  localparam logic [1:0]    LAST = 2'(WPB - 1);
  logic [BUF_W-1:0] shreg, stream, nbuf;
  logic [CW-1:0]    cnt, sh;
  logic             push, pop, started, hdr_v, rd, wr;
  logic [1:0]       idx, hdr_r, hn, wi;
  logic [1:0]       hq [2];
  assign tx_block_ready  = rst_n && (cnt <= OW);
  assign tx_header       = INLINE_HDR ? 2'b00 : hdr_r;
  assign tx_header_valid = !INLINE_HDR && hdr_v;
  always_comb begin
    push   = tx_block_valid && tx_block_ready;
    pop    = (!tx_data_valid || tx_data_ready) && cnt >= OW;
    stream = INLINE_HDR ? BUF_W'({tx_block[63:0], tx_block[65:64]}) : BUF_W'(tx_block[63:0]);
    sh     = pop ? cnt - OW : cnt;
    nbuf   = (pop ? shreg >> OUT_W : shreg) | (push ? stream << sh : '0);
    rd     = !INLINE_HDR && pop && idx == 2'd0;
    wr     = !INLINE_HDR && push;
    wi     = hn - {1'b0, rd};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg         <= '0;
      cnt           <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      tx_underrun   <= 1'b0;
      started       <= 1'b0;
      hdr_v         <= 1'b0;
      hdr_r         <= 2'b00;
      idx           <= 2'd0;
      hn            <= 2'd0;
      hq[0]         <= 2'b00;
      hq[1]         <= 2'b00;
    end else begin
      shreg       <= nbuf;
      cnt         <= cnt + (push ? BK : '0) - (pop ? OW : '0);
      tx_underrun <= started && tx_data_ready && !tx_data_valid && cnt < OW;
      if (pop) begin
        tx_data       <= shreg[OUT_W-1:0];
        tx_data_valid <= 1'b1;
        started       <= 1'b1;
        idx           <= idx == LAST ? 2'd0 : idx + 2'd1;
        hdr_v         <= idx == 2'd0;
        if (idx == 2'd0) hdr_r <= hq[0];
      end else if (!tx_data_valid || tx_data_ready) begin
        tx_data_valid <= 1'b0;
        hdr_v         <= 1'b0;
      end
      // the read shift happens first so a same-cycle write lands in the freed slot
      if (rd) hq[0] <= hq[1];
      if (wr) hq[wi[0]] <= tx_block[65:64];
      hn <= hn + {1'b0, wr} - {1'b0, rd};
    end
  end
endmodule

// File: tb/tb_pcs_10g_tx_gearbox_param.sv
// tb_pcs_10g_tx_gearbox_param: inline OUT_W=32 and separate-header OUT_W=16 gearboxes against a bit-FIFO model
module tb_pcs_10g_tx_gearbox_param;
  logic        clk = 1'b0;
  logic        rn [2];
  logic [65:0] blk [2];
  logic        bv [2], dr [2], rdy [2], dv [2], hv [2], und [2];
  logic [1:0]  hd [2];
  logic [31:0] data0;
  logic [15:0] data1;
  bit          chk_en = 1'b0;
  int          pass = 0, total = 0;
  bit          bq [2][1024];
  int          wp [2], rp [2];
  logic [63:0] e_data [2];
  bit          e_v [2], e_hv [2], e_und [2], started [2];
  logic [1:0]  e_hdr [2];
  logic [1:0]  hq [$];

  always #5 clk = ~clk;

  pcs_10g_tx_gearbox_param #(.OUT_W(32), .INLINE_HDR(1'b1)) dut0 (
    .clk(clk), .rst_n(rn[0]), .tx_block(blk[0]), .tx_block_valid(bv[0]), .tx_block_ready(rdy[0]),
    .tx_data(data0), .tx_data_valid(dv[0]), .tx_data_ready(dr[0]), .tx_header(hd[0]),
    .tx_header_valid(hv[0]), .tx_underrun(und[0]));

  pcs_10g_tx_gearbox_param #(.OUT_W(16), .INLINE_HDR(1'b0)) dut1 (
    .clk(clk), .rst_n(rn[1]), .tx_block(blk[1]), .tx_block_valid(bv[1]), .tx_block_ready(rdy[1]),
    .tx_data(data1), .tx_data_valid(dv[1]), .tx_data_ready(dr[1]), .tx_header(hd[1]),
    .tx_header_valid(hv[1]), .tx_underrun(und[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // model: the gearbox is a FIFO of stream bits; a word is the next OUT_W bits, a header goes with every 64th bit
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int ow, cnt, sl;
      bit push, pop, un;
      logic [63:0] w;
      logic [65:0] s;
      ow = (i == 0) ? 32 : 16;
      if (!rn[i]) begin
        wp[i] = 0; rp[i] = 0; e_data[i] = '0; e_v[i] = 0; e_hv[i] = 0;
        e_hdr[i] = 2'b00; e_und[i] = 0; started[i] = 0;
        if (i == 1) hq.delete();
      end else begin
        cnt  = wp[i] - rp[i];
        push = bv[i] && cnt <= ow;
        pop  = (!e_v[i] || dr[i]) && cnt >= ow;
        un   = started[i] && dr[i] && !e_v[i] && cnt < ow;
        if (pop) begin
          w = '0;
          for (int k = 0; k < ow; k++) w[k] = bq[i][(rp[i] + k) % 1024];
          e_data[i] = w; e_v[i] = 1; started[i] = 1;
          if (i == 1) begin
            e_hv[i] = (rp[i] % 64) == 0;
            if (e_hv[i]) e_hdr[i] = hq.pop_front();
          end
          rp[i] += ow;
        end else if (!e_v[i] || dr[i]) begin
          e_v[i] = 0; e_hv[i] = 0;
        end
        if (push) begin
          s  = (i == 0) ? {blk[i][63:0], blk[i][65:64]} : {2'b00, blk[i][63:0]};
          sl = (i == 0) ? 66 : 64;
          for (int k = 0; k < sl; k++) bq[i][(wp[i] + k) % 1024] = s[k];
          wp[i] += sl;
          if (i == 1) hq.push_back(blk[i][65:64]);
        end
        e_und[i] = un;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ready%0d", i), 64'(rdy[i]), 64'(rn[i] && (wp[i] - rp[i]) <= ((i == 0) ? 32 : 16)));
        chk($sformatf("valid%0d", i), 64'(dv[i]), 64'(e_v[i]));
        if (e_v[i]) chk($sformatf("data%0d", i), (i == 0) ? 64'(data0) : 64'(data1), e_data[i]);
        chk($sformatf("hdr_valid%0d", i), 64'(hv[i]), 64'(e_hv[i]));
        chk($sformatf("hdr%0d", i), 64'(hd[i]), 64'(e_hdr[i]));
        chk($sformatf("underrun%0d", i), 64'(und[i]), 64'(e_und[i]));
      end
    end
  end

  initial begin
    int n;
    logic acc;
    rn = '{1'b0, 1'b0}; bv = '{1'b0, 1'b0}; dr = '{1'b0, 1'b0};
    blk = '{66'h0, 66'h0};
    cyc(); cyc();
    chk_en = 1'b1;
    chk("rst_outputs0", {data0, hd[0], hv[0], und[0], dv[0], rdy[0]}, 64'h0);
    chk("rst_outputs1", {data1, hd[1], hv[1], und[1], dv[1], rdy[1]}, 64'h0);
    rn = '{1'b1, 1'b1};
    dr[0] = 1'b1; blk[0] = {2'b01, 64'h0123_4567_89AB_CDEF}; bv[0] = 1'b1;
    cyc();
    bv[0] = 1'b0;
    cyc();
    chk("inl_word0", data0, 32'h26AF_37BD);
    chk("inl_valid0", dv[0], 1);
    cyc();
    chk("inl_word1", data0, 32'h048D_159E);
    chk("inl_cnt_left", wp[0] - rp[0], 2);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      blk[0] = {n[0] ? 2'b01 : 2'b10, 64'h9E37_79B9_7F4A_7C15 * 64'(n + 1)};
      bv[0] = 1'b1;
      dr[0] = (c >= 30 && c < 35) ? 1'b0 : 1'b1;
      acc = rdy[0];
      cyc();
      if (acc) n++;
      if (c == 34) begin
        chk("stall_ready", rdy[0], 0);
        chk("stall_valid", dv[0], 1);
      end
    end
    bv[0] = 1'b0;
    repeat (10) cyc();
    chk("starve_underrun", und[0], 1);
    chk("starve_valid", dv[0], 0);
    cyc();
    chk("starve_underrun_again", und[0], 1);
    dr[1] = 1'b1; blk[1] = {2'b10, 64'hFEDC_BA98_7654_3210}; bv[1] = 1'b1;
    cyc();
    bv[1] = 1'b0;
    cyc();
    chk("sep_word0", data1, 16'h3210);
    chk("sep_hv0", hv[1], 1);
    chk("sep_hdr0", hd[1], 2'b10);
    cyc();
    chk("sep_word1", data1, 16'h7654);
    chk("sep_hv1", hv[1], 0);
    chk("sep_hdr_hold", hd[1], 2'b10);
    n = 1;
    for (int c = 0; c < 38; c++) begin
      blk[1] = {n[0] ? 2'b01 : 2'b10, 64'h0F1E_2D3C_4B5A_6978 ^ (64'hDEAD_BEEF_0000_0001 * 64'(n))};
      bv[1] = 1'b1;
      acc = rdy[1];
      cyc();
      if (acc) n++;
    end
    rn[1] = 1'b0; bv[1] = 1'b0;
    cyc();
    chk("midrst_outputs1", {data1, hd[1], hv[1], und[1], dv[1], rdy[1]}, 64'h0);
    rn[1] = 1'b1; blk[1] = {2'b01, 64'hCAFE_F00D_1234_5678}; bv[1] = 1'b1;
    cyc();
    bv[1] = 1'b0;
    cyc();
    chk("midrst_word0", data1, 16'h5678);
    chk("midrst_hv0", hv[1], 1);
    chk("midrst_hdr0", hd[1], 2'b01);
    repeat (6) cyc();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
